// File: rtl/pipe_pkg.sv
// Shared front-end pipeline types and helpers: IF/ID payload layout, NOP word, width helper.
package pipe_pkg;

  // Width helper that never returns zero, so single-entry buffers still get a 1-bit pointer.
  function automatic int clog2(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [15:0] opinfo;
    logic [63:0] imm;
    logic [63:0] pred_pc;
    logic [7:0]  sys_info;
  } ifid_t;

  localparam int PIPE_IFID_W = $bits(ifid_t);

endpackage

// File: rtl/pipe_buf_ctrl.sv
// Pointer/occupancy controller for the elastic stage buffer: push/pop/flush decode and full/empty.
module pipe_buf_ctrl
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic             out_ready_i,
  output logic             push_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  // Flags come from registered count only, keeping ready free of downstream paths.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push    = in_valid_i & ~full_o & ~flush_i;
  assign pop     = ~empty_o & out_ready_i & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (DEPTH == 1) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = (DEPTH == 1) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign push_o   = push;
  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// DEPTH-entry elastic pipeline-stage register with flush and bubble output.
// Define PIPE_STAGE_BUF_STATS_EN to add stall_cnt_o / hiwater_o statistics outputs.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int               DATA_W = 64,
  parameter int               DEPTH  = 2,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_W-1:0]        in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_W-1:0]        out_data_o,
`ifdef PIPE_STAGE_BUF_STATS_EN
  output logic [31:0]              stall_cnt_o,
  output logic [$clog2(DEPTH):0]   hiwater_o,
`endif
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              push, full, empty;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  pipe_buf_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .out_ready_i (out_ready_i),
    .push_o      (push),
    .wr_ptr_o    (wr_ptr),
    .rd_ptr_o    (rd_ptr),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  // Payload storage carries no reset; validity lives entirely in the controller.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= in_data_i;
  end

  assign in_ready_o  = ~full;
  assign out_valid_o = ~empty;
  assign out_data_o  = empty ? BUBBLE : mem[rd_ptr];
  assign count_o     = count;

`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [31:0]      stall_cnt_q;
  logic [CNT_W-1:0] hiwater_q;

  // High-water mark survives flush; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      hiwater_q   <= '0;
    end else begin
      if (in_valid_i && full && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (count > hiwater_q)
        hiwater_q <= count;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign hiwater_o   = hiwater_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a DEPTH=2 and a DEPTH=4 instance with an 8-bit payload.
module tb_pipe_stage_buf;

  localparam logic [7:0] BUB = 8'h13;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         checks = 0;
  int         errors = 0;

  logic       f2 = 0, v2 = 0, r2 = 0, ir2, ov2;
  logic [7:0] d2 = 0, od2;
  logic [1:0] c2;
  logic       f4 = 0, v4 = 0, r4 = 0, ir4, ov4;
  logic [7:0] d4 = 0, od4;
  logic [2:0] c4;
`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [31:0] st2, st4;
  logic [1:0]  hw2;
  logic [2:0]  hw4;
`endif

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(8), .DEPTH(2), .BUBBLE(BUB)) dut2 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(f2),
    .in_valid_i(v2), .in_ready_o(ir2), .in_data_i(d2),
    .out_valid_o(ov2), .out_ready_i(r2), .out_data_o(od2),
`ifdef PIPE_STAGE_BUF_STATS_EN
    .stall_cnt_o(st2), .hiwater_o(hw2),
`endif
    .count_o(c2)
  );

  pipe_stage_buf #(.DATA_W(8), .DEPTH(4), .BUBBLE(BUB)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(f4),
    .in_valid_i(v4), .in_ready_o(ir4), .in_data_i(d4),
    .out_valid_o(ov4), .out_ready_i(r4), .out_data_o(od4),
`ifdef PIPE_STAGE_BUF_STATS_EN
    .stall_cnt_o(st4), .hiwater_o(hw4),
`endif
    .count_o(c4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL rst_ov2 got %0b want 0", ov2); end
    checks++; if (ir2 !== 1'b1) begin errors++; $display("FAIL rst_ir2 got %0b want 1", ir2); end
    checks++; if (c2 !== 2'd0) begin errors++; $display("FAIL rst_c2 got %0d want 0", c2); end
    checks++; if (od2 !== BUB) begin errors++; $display("FAIL rst_od2 got %h want %h", od2, BUB); end
    checks++; if (c4 !== 3'd0 || ov4 !== 1'b0 || ir4 !== 1'b1 || od4 !== BUB) begin
      errors++; $display("FAIL rst_dut4 got c=%0d ov=%0b ir=%0b od=%h want 0/0/1/%h", c4, ov4, ir4, od4, BUB);
    end
    tick();
    rst_n = 1'b1;
    v2 = 1; d2 = 8'h77; r2 = 0;
    tick();
    tick();
    v2 = 0;
    checks++; if (c2 !== 2'd2) begin errors++; $display("FAIL mid_fill got %0d want 2", c2); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (c2 !== 2'd0 || ov2 !== 1'b0 || od2 !== BUB) begin
      errors++; $display("FAIL async_rst got c=%0d ov=%0b od=%h want 0/0/%h", c2, ov2, od2, BUB);
    end
    tick();
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] tbl [3] = '{8'hA1, 8'hA2, 8'hA3};
    r2 = 1;
    for (int i = 0; i < 3; i++) begin
      v2 = 1; d2 = tbl[i];
      tick();
      checks++; if (ov2 !== 1'b1 || od2 !== tbl[i]) begin
        errors++; $display("FAIL b2b_out[%0d] got ov=%0b od=%h want 1/%h", i, ov2, od2, tbl[i]);
      end
      checks++; if (c2 !== 2'd1 || ir2 !== 1'b1) begin
        errors++; $display("FAIL b2b_cnt[%0d] got c=%0d ir=%0b want 1/1", i, c2, ir2);
      end
      $display("b2b push %h out %h count %0d", tbl[i], od2, c2);
    end
    v2 = 0;
    tick();
    checks++; if (c2 !== 2'd0 || od2 !== BUB) begin
      errors++; $display("FAIL b2b_drain got c=%0d od=%h want 0/%h", c2, od2, BUB);
    end
  endtask

  task automatic test_stall();
    logic       tv [6] = '{1, 1, 1, 1, 1, 0};
    logic [7:0] td [6] = '{8'h11, 8'h12, 8'h13, 8'h13, 8'h13, 8'h00};
    logic       tr [6] = '{0, 0, 0, 1, 1, 1};
    logic [1:0] ec [6] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
    logic       ei [6] = '{1, 0, 0, 1, 1, 1};
    logic [7:0] eo [6] = '{8'h11, 8'h11, 8'h11, 8'h12, 8'h13, BUB};
    for (int i = 0; i < 6; i++) begin
      v2 = tv[i]; d2 = td[i]; r2 = tr[i];
      tick();
      checks++; if (c2 !== ec[i] || ir2 !== ei[i]) begin
        errors++; $display("FAIL stall_cnt[%0d] got c=%0d ir=%0b want %0d/%0b", i, c2, ir2, ec[i], ei[i]);
      end
      checks++; if (od2 !== eo[i]) begin
        errors++; $display("FAIL stall_out[%0d] got %h want %h", i, od2, eo[i]);
      end
      $display("stall row %0d in %h ready_o %0b count %0d out %h", i, td[i], ir2, c2, od2);
    end
    v2 = 0; r2 = 0;
  endtask

  task automatic test_wrap();
    logic [7:0] q [$];
    int sent = 0, got = 0;
    bit do_push, do_pop;
    for (int cyc = 0; cyc < 60 && (sent < 10 || q.size() > 0); cyc++) begin
      v4 = (sent < 10); d4 = 8'h30 + 8'(sent); r4 = (cyc % 2 == 0);
      checks++; if (c4 !== 3'(q.size()) || ir4 !== (q.size() != 4) || ov4 !== (q.size() != 0)) begin
        errors++; $display("FAIL wrap_state[%0d] got c=%0d ir=%0b ov=%0b want c=%0d", cyc, c4, ir4, ov4, q.size());
      end
      checks++; if (c4 > 3'd4) begin errors++; $display("FAIL wrap_max got %0d want <=4", c4); end
      do_pop  = r4 && (q.size() != 0);
      do_push = v4 && (q.size() != 4);
      if (do_pop) begin
        checks++; if (od4 !== q[0]) begin
          errors++; $display("FAIL wrap_data[%0d] got %h want %h", got, od4, q[0]);
        end
        $display("wrap pop %0d data %h", got, od4);
        got++;
      end
      tick();
      if (do_pop) void'(q.pop_front());
      if (do_push) begin q.push_back(d4); sent++; end
    end
    checks++; if (sent != 10 || got != 10) begin
      errors++; $display("FAIL wrap_timeout got sent=%0d popped=%0d want 10/10", sent, got);
    end
    v4 = 0; r4 = 0;
  endtask

  task automatic test_flush();
    r2 = 0; v2 = 1; d2 = 8'h21;
    tick();
    d2 = 8'h22;
    tick();
    checks++; if (c2 !== 2'd2) begin errors++; $display("FAIL flush_fill got %0d want 2", c2); end
    f2 = 1; v2 = 1; d2 = 8'hFF; r2 = 1;
    tick();
    f2 = 0; v2 = 0;
    checks++; if (c2 !== 2'd0 || ov2 !== 1'b0 || od2 !== BUB || ir2 !== 1'b1) begin
      errors++; $display("FAIL flush_clear got c=%0d ov=%0b od=%h ir=%0b want 0/0/%h/1", c2, ov2, od2, ir2, BUB);
    end
    $display("flush count %0d out %h", c2, od2);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ov2 !== 1'b0 || od2 === 8'hFF) begin
        errors++; $display("FAIL flush_leak[%0d] got ov=%0b od=%h want 0/%h", i, ov2, od2, BUB);
      end
    end
    v2 = 1; d2 = 8'h55; r2 = 0;
    tick();
    checks++; if (c2 !== 2'd1 || od2 !== 8'h55) begin
      errors++; $display("FAIL flush_after got c=%0d od=%h want 1/55", c2, od2);
    end
    v2 = 0; r2 = 1;
    tick();
    checks++; if (c2 !== 2'd0) begin errors++; $display("FAIL flush_drain got %0d want 0", c2); end
    r2 = 0;
  endtask

`ifdef PIPE_STAGE_BUF_STATS_EN
  task automatic test_stats();
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (st2 !== 32'd0 || hw2 !== 2'd0) begin
      errors++; $display("FAIL stats_rst got stall=%0d hw=%0d want 0/0", st2, hw2);
    end
    r2 = 0; v2 = 1; d2 = 8'h66;
    for (int i = 0; i < 7; i++) tick();
    v2 = 0;
    checks++; if (st2 !== 32'd5 || hw2 !== 2'd2) begin
      errors++; $display("FAIL stats_full got stall=%0d hw=%0d want 5/2", st2, hw2);
    end
    f2 = 1;
    tick();
    f2 = 0;
    checks++; if (st2 !== 32'd5 || hw2 !== 2'd2 || c2 !== 2'd0) begin
      errors++; $display("FAIL stats_flush got stall=%0d hw=%0d c=%0d want 5/2/0", st2, hw2, c2);
    end
    $display("stats stall %0d hiwater %0d", st2, hw2);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_flush();
`ifdef PIPE_STAGE_BUF_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
